bf2i_bundle_ctrl: RTL and testbench
===================================

// Module: bf2i_bundle_ctrl
// PURPOSE
//  Frame sequencer for the parallel BF2I butterfly bundle (DEPTH lanes, registered, gated by en).
//  Accepts one frame of FRAME_BLKS input blocks over a valid/ready handshake and drives the bundle's en.
//  Tracks valid tokens through the PIPE_LAT-deep datapath and presents out_valid/out_last/out_blk to the next stage.
//  Sits between the input block buffer and the next butterfly/twiddle stage; applies downstream backpressure as a global stall.
// PARAMETERS
//  FRAME_BLKS  32  input blocks per frame (512-pt FFT / 16 lanes); must be >= 2
//  PIPE_LAT    1   register stages in the controlled datapath (BF2I bundle = 1); range 1..8
//  BLK_W       5   width of block index; $clog2(FRAME_BLKS)
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  start       in   1      pulse: begin a frame (honoured only in IDLE)
//  in_valid    in   1      upstream block present on din_R/din_Q
//  in_ready    out  1      controller accepts block this cycle
//  in_blk      out  BLK_W  index of block being accepted (twiddle/ROM address)
//  bf_en       out  1      enable to butterfly bundle registers
//  out_valid   out  1      valid block at bundle dout_R/dout_Q
//  out_ready   in   1      downstream accepts output block
//  out_blk     out  BLK_W  index of block at output
//  out_last    out  1      output block is last of frame (qualified by out_valid)
//  busy        out  1      state != IDLE
//  frame_done  out  1      one-cycle pulse when last block handed off
// BEHAVIOUR
//  Reset: state=IDLE; in_ready, bf_en, out_valid, out_last, busy, frame_done = 0; in_blk, out_blk = 0; valid pipe cleared.
//  FSM IDLE -> RUN on start; RUN -> DRAIN on acceptance of block FRAME_BLKS-1;
//    DRAIN -> DONE when valid pipe empty after last handoff; DONE -> IDLE next cycle (frame_done=1 in DONE).
//  stall = out_valid & ~out_ready; advance = ~stall.
//  bf_en = advance & busy (combinational); datapath holds when bf_en=0, so no data lost under stall.
//  in_ready = (state==RUN) & advance; accept = in_valid & in_ready; in_blk = accept counter (0..FRAME_BLKS-1).
//  Valid pipe: PIPE_LAT-bit shift reg + parallel BLK_W index pipe; on advance, shifts in accept/in_blk.
//  Bubbles (in_valid=0 while advancing) enter pipe as invalid; out_valid = pipe[PIPE_LAT-1].
//  out_last = out_valid & (out_blk == FRAME_BLKS-1). Handoff = out_valid & out_ready.
//  Latency: block accepted at edge N appears out_valid after PIPE_LAT advancing edges (PIPE_LAT=1: next cycle).
//  Throughput: 1 block/cycle when in_valid and out_ready held high.
//  start while busy: ignored, no effect on counters. start and DONE same cycle: ignored (IDLE first).
//  in_blk counter wraps to 0 on last accept; no acceptance in DRAIN/DONE/IDLE regardless of in_valid.
//  out_ready low in DRAIN: pipe frozen, DRAIN held until handoff completes.
//  Reset asserted mid-frame: immediate return to reset values; partial frame discarded, no frame_done.
// CONFIGURATION
//  BF2I_CTRL_PERF_EN defined: adds outputs perf_cycles[15:0] (cycles in RUN+DRAIN of last frame)
//    and perf_stalls[15:0] (cycles with stall=1 during that frame); both cleared on start, saturate at 16'hFFFF,
//    hold after frame_done; reset to 0.
//  Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 Reset: rst_n=0 mid-sim with in_valid=1 -> all outputs 0, in_blk=0, state IDLE within same cycle (async).
//  2 Streaming: start, in_valid=1, out_ready=1, PIPE_LAT=1 -> in_ready 32 cycles, out_valid cycles 2..33,
//     out_blk 0..31, out_last only on blk 31, frame_done 1 cycle after last handoff.
//  3 Bubbles: in_valid toggled 1,0,1,0 -> bf_en stays 1, out_valid mirrors pattern 1 cycle later, 32 blocks total.
//  4 Backpressure: out_ready=0 for 3 cycles at out_blk=5 -> bf_en=0, in_ready=0, out_blk held 5, no index skipped/repeated.
//  5 Illegal start: start pulsed during RUN at in_blk=10 -> counter unaffected, frame completes normally at blk 31.
//  6 PERF_EN build: 32 blocks with 4 stall cycles -> perf_stalls=4, perf_cycles=37 (PIPE_LAT=1); next start clears both.

Source files
------------

// File: rtl/bf2i_bundle_ctrl_if.sv
// Handshake bundle between the BF2I frame sequencer and its neighbours.
// Input side: block source -> controller (in_valid/in_ready/in_blk).
// Output side: controller -> next stage (out_valid/out_ready/out_blk/out_last).
// master: the surrounding environment (source + sink); slave: the controller.
interface bf2i_bundle_ctrl_if #(
  parameter int BLK_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [BLK_W-1:0] in_blk;
  logic             out_valid;
  logic             out_ready;
  logic [BLK_W-1:0] out_blk;
  logic             out_last;

  modport master (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  in_blk,
    input  out_valid,
    input  out_blk,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output in_blk,
    output out_valid,
    output out_blk,
    output out_last
  );
endinterface

// File: rtl/bf2i_bundle_ctrl.sv
// Frame sequencer for the parallel BF2I butterfly bundle.
// Accepts FRAME_BLKS blocks per frame, drives the bundle enable, tracks valid
// tokens through the PIPE_LAT-deep datapath and presents them downstream.
// Downstream backpressure (out_valid & ~out_ready) freezes the whole pipe.
// Optional feature macro: BF2I_CTRL_PERF_EN adds perf_cycles/perf_stalls.
module bf2i_bundle_ctrl #(
  parameter int FRAME_BLKS = 32,
  parameter int PIPE_LAT   = 1,
  parameter int BLK_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  bf2i_bundle_ctrl_if.slave bus,
  output logic             bf_en,
  output logic             busy,
  output logic             frame_done
`ifdef BF2I_CTRL_PERF_EN
  ,
  output logic [15:0]      perf_cycles,
  output logic [15:0]      perf_stalls
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [BLK_W-1:0] LAST_BLK = BLK_W'(FRAME_BLKS - 1);

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic [BLK_W-1:0]    blk_cnt;
  logic                stall;
  logic                advance;
  logic                accept;

  // Token pipe: index 0 is the newest stage, PIPE_LAT-1 faces the output.
  logic [PIPE_LAT-1:0] vld_p;
  logic [PIPE_LAT-1:0] vld_nxt;
  logic [BLK_W-1:0]    blk_p [PIPE_LAT];

  // Saturating 16-bit increment for the performance counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Handshake and enable decode; a stalled output freezes everything.
  assign stall         = vld_p[PIPE_LAT-1] & ~bus.out_ready;
  assign advance       = ~stall;
  assign busy          = (state != IDLE);
  assign bf_en         = advance & busy;
  assign bus.in_ready  = (state == RUN) & advance;
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.in_blk    = blk_cnt;
  assign bus.out_valid = vld_p[PIPE_LAT-1];
  assign bus.out_blk   = blk_p[PIPE_LAT-1];
  assign bus.out_last  = vld_p[PIPE_LAT-1] & (blk_p[PIPE_LAT-1] == LAST_BLK);
  assign frame_done    = (state == DONE);

  // Next contents of the valid pipe: shift in the accept flag when advancing.
  always_comb begin
    vld_nxt = vld_p;
    if (advance) begin
      vld_nxt[0] = accept;
      for (int i = 1; i < PIPE_LAT; i++) begin
        vld_nxt[i] = vld_p[i-1];
      end
    end
  end

  // Frame FSM: DRAIN ends once the last token has left the pipe.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && (blk_cnt == LAST_BLK)) state_nxt = DRAIN;
      DRAIN:   if (vld_nxt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Accept counter: block index handed to the twiddle/ROM address, wraps per frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt <= '0;
    end else if (accept) begin
      blk_cnt <= (blk_cnt == LAST_BLK) ? '0 : blk_cnt + BLK_W'(1);
    end
  end

  // Valid pipe register; bubbles enter as zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p <= '0;
    end else begin
      vld_p <= vld_nxt;
    end
  end

  // Index pipe travels alongside the valid pipe and holds under stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        blk_p[i] <= '0;
      end
    end else if (advance) begin
      blk_p[0] <= blk_cnt;
      for (int i = 1; i < PIPE_LAT; i++) begin
        blk_p[i] <= blk_p[i-1];
      end
    end
  end

`ifdef BF2I_CTRL_PERF_EN
  // Frame statistics: cleared on an accepted start, counted while RUN/DRAIN, held afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if ((state == IDLE) && start) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if ((state == RUN) || (state == DRAIN)) begin
      perf_cycles <= sat_inc16(perf_cycles);
      if (stall) perf_stalls <= sat_inc16(perf_stalls);
    end
  end
`endif

endmodule

// File: tb/tb_bf2i_bundle_ctrl.sv
// Self-checking bench for bf2i_bundle_ctrl (FRAME_BLKS=32, PIPE_LAT=1).
// Reference model: frame phase, accept count and a queue of in-flight block
// indices (-1 = bubble); plus an in-order handoff scoreboard.
// Build with +define+BF2I_CTRL_PERF_EN to also check the perf counters.
module tb_bf2i_bundle_ctrl;
  localparam int FB = 32;
  localparam int PL = 1;
  localparam int BW = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic bf_en;
  logic busy;
  logic frame_done;
`ifdef BF2I_CTRL_PERF_EN
  logic [15:0] perf_cycles;
  logic [15:0] perf_stalls;
`endif

  always #5 clk = ~clk;

  bf2i_bundle_ctrl_if #(.BLK_W(BW)) bus ();

  bf2i_bundle_ctrl #(
    .FRAME_BLKS(FB),
    .PIPE_LAT  (PL),
    .BLK_W     (BW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus),
    .bf_en     (bf_en),
    .busy      (busy),
    .frame_done(frame_done)
`ifdef BF2I_CTRL_PERF_EN
    ,
    .perf_cycles(perf_cycles),
    .perf_stalls(perf_stalls)
`endif
  );

  // Model state
  int phase;      // 0 idle, 1 accepting, 2 draining, 3 done
  int acc;        // blocks accepted so far in this frame
  int q[$];       // q[0] newest, q[PL-1] at output; -1 = bubble
  int exp_hand;
  int n_hand;
  int pc;
  int ps;
  int cyc;
  bit p_stall;
  bit p_ov;
  bit p_acc;
  int p_oblk;

  // Samples taken at the falling edge
  logic s_in_ready, s_bf_en, s_ov, s_last, s_fd, s_busy;
  logic [BW-1:0] s_in_blk, s_out_blk;

  int n_checks;
  int n_fail;

  function void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function void model_reset();
    phase = 0;
    acc = 0;
    q.delete();
    for (int i = 0; i < PL; i++) q.push_back(-1);
    exp_hand = 0;
    pc = 0;
    ps = 0;
  endfunction

  function int sat16(input int v);
    return (v >= 16'hFFFF) ? 16'hFFFF : v + 1;
  endfunction

  // Compare DUT outputs against the model for the current cycle.
  task automatic compare();
    s_in_ready = bus.in_ready;
    s_bf_en    = bf_en;
    s_ov       = bus.out_valid;
    s_last     = bus.out_last;
    s_fd       = frame_done;
    s_busy     = busy;
    s_in_blk   = bus.in_blk;
    s_out_blk  = bus.out_blk;
    if (!rst_n) begin
      chk("rst_in_ready", 32'(s_in_ready), 0);
      chk("rst_bf_en", 32'(s_bf_en), 0);
      chk("rst_out_valid", 32'(s_ov), 0);
      chk("rst_out_last", 32'(s_last), 0);
      chk("rst_busy", 32'(s_busy), 0);
      chk("rst_frame_done", 32'(s_fd), 0);
      chk("rst_in_blk", 32'(s_in_blk), 0);
      chk("rst_out_blk", 32'(s_out_blk), 0);
`ifdef BF2I_CTRL_PERF_EN
      chk("rst_perf_cycles", 32'(perf_cycles), 0);
      chk("rst_perf_stalls", 32'(perf_stalls), 0);
`endif
      return;
    end
    p_ov    = (q[PL-1] != -1);
    p_oblk  = p_ov ? q[PL-1] : 0;
    p_stall = p_ov && !bus.out_ready;
    p_acc   = bus.in_valid && (phase == 1) && !p_stall;
    chk("in_ready", 32'(s_in_ready), 32'(phase == 1 && !p_stall));
    chk("in_blk", 32'(s_in_blk), 32'(acc));
    chk("bf_en", 32'(s_bf_en), 32'(phase != 0 && !p_stall));
    chk("out_valid", 32'(s_ov), 32'(p_ov));
    chk("busy", 32'(s_busy), 32'(phase != 0));
    chk("frame_done", 32'(s_fd), 32'(phase == 3));
    chk("out_last", 32'(s_last), 32'(p_ov && p_oblk == FB - 1));
    if (p_ov) chk("out_blk", 32'(s_out_blk), 32'(p_oblk));
    if (p_ov && bus.out_ready) begin
      chk("handoff_order", 32'(s_out_blk), 32'(exp_hand));
      exp_hand = (exp_hand + 1) % FB;
      n_hand++;
    end
`ifdef BF2I_CTRL_PERF_EN
    chk("perf_cycles", 32'(perf_cycles), 32'(pc));
    chk("perf_stalls", 32'(perf_stalls), 32'(ps));
`endif
  endtask

  // Advance the model across one rising edge.
  task automatic model_step();
    bit empty;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (phase == 0 && start) begin
      pc = 0;
      ps = 0;
    end else if (phase == 1 || phase == 2) begin
      pc = sat16(pc);
      if (p_stall) ps = sat16(ps);
    end
    if (!p_stall) begin
      q.push_front(p_acc ? acc : -1);
      void'(q.pop_back());
    end
    empty = 1'b1;
    foreach (q[i]) if (q[i] != -1) empty = 1'b0;
    case (phase)
      0: if (start) phase = 1;
      1: if (p_acc && acc == FB - 1) phase = 2;
      2: if (empty) phase = 3;
      default: phase = 0;
    endcase
    if (p_acc) acc = (acc + 1) % FB;
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  // One frame with optional bubbles, a backpressure burst and an illegal start.
  task automatic run_frame(input bit bubble, input int bp_at, input int bp_cycles,
                           input int ill_at, output int n_bf_off, output bit got_fd);
    int bp_left;
    int ill_state;
    n_bf_off = 0;
    got_fd = 1'b0;
    bp_left = -1;
    ill_state = 0;
    n_hand = 0;
    start = 1'b1;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 300 && !got_fd; k++) begin
      tick();
      if (bubble) bus.in_valid = ~bus.in_valid;
      if (s_busy && !s_bf_en && bp_left <= 0) n_bf_off++;
      if (s_fd) got_fd = 1'b1;
      if (bp_left > 0) begin
        chk("bp_bf_en", 32'(s_bf_en), 0);
        chk("bp_in_ready", 32'(s_in_ready), 0);
        chk("bp_out_blk", 32'(s_out_blk), 32'(bp_at));
        bp_left--;
        if (bp_left == 0) bus.out_ready = 1'b1;
      end else if (bp_left < 0 && bp_cycles > 0 && s_ov && s_out_blk == BW'(bp_at - 1)) begin
        bus.out_ready = 1'b0;
        bp_left = bp_cycles;
      end
      if (ill_state == 1) begin
        chk("illegal_start_in_blk", 32'(s_in_blk), 32'(ill_at + 1));
        start = 1'b0;
        ill_state = 2;
      end else if (ill_at >= 0 && ill_state == 0 && s_in_ready && s_in_blk == BW'(ill_at)) begin
        start = 1'b1;
        ill_state = 1;
      end
    end
    chk("frame_done_seen", 32'(got_fd), 1);
    chk("frame_handoffs", 32'(n_hand), FB);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    start = 1'b0;
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, rel, nir, nov, nlast, first_ov, fd_rel, n_off;
    bit got_fd;
    n_checks = 0;
    n_fail = 0;
    cyc = 0;
    n_hand = 0;
    rst_n = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Streaming frame: exact timing pinned by hand.
    n_hand = 0;
    nir = 0; nov = 0; nlast = 0; first_ov = -1; fd_rel = -1; got_fd = 1'b0;
    start = 1'b1;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    c0 = cyc;
    tick();
    start = 1'b0;
    for (int k = 0; k < 60 && !got_fd; k++) begin
      tick();
      rel = cyc - 1 - c0;
      if (s_in_ready) nir++;
      if (s_ov) begin
        nov++;
        if (first_ov < 0) first_ov = rel;
      end
      if (s_last) nlast++;
      if (s_fd) begin
        got_fd = 1'b1;
        fd_rel = rel;
      end
    end
    chk("stream_done_seen", 32'(got_fd), 1);
    chk("stream_in_ready_cycles", 32'(nir), 32);
    chk("stream_out_valid_cycles", 32'(nov), 32);
    chk("stream_first_out_cycle", 32'(first_ov), 2);
    chk("stream_frame_done_cycle", 32'(fd_rel), 34);
    chk("stream_out_last_count", 32'(nlast), 1);
    chk("stream_handoffs", 32'(n_hand), 32);
    bus.in_valid = 1'b0;
    tick();

    // Bubbles: enable never drops without backpressure.
    run_frame(1'b1, 0, 0, -1, n_off, got_fd);
    chk("bubble_bf_en_low_cycles", 32'(n_off), 0);

    // Backpressure at block 5 for 3 cycles.
    run_frame(1'b0, 5, 3, -1, n_off, got_fd);

    // Illegal start during RUN at block 10.
    run_frame(1'b0, 0, 0, 10, n_off, got_fd);

    // Four stall cycles, then perf counter values.
    run_frame(1'b0, 5, 4, -1, n_off, got_fd);
`ifdef BF2I_CTRL_PERF_EN
    chk("perf_stalls_frame", 32'(perf_stalls), 4);
    chk("perf_cycles_frame", 32'(perf_cycles), 37);
    start = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    start = 1'b0;
    chk("perf_cycles_cleared", 32'(perf_cycles), 0);
    chk("perf_stalls_cleared", 32'(perf_stalls), 0);
    got_fd = 1'b0;
    for (int k = 0; k < 100 && !got_fd; k++) begin
      tick();
      if (s_fd) got_fd = 1'b1;
    end
    chk("perf_frame_done_seen", 32'(got_fd), 1);
    bus.in_valid = 1'b0;
    tick();
`endif

    // Asynchronous reset mid-frame with in_valid held high.
    start = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 12; k++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_in_ready", 32'(bus.in_ready), 0);
    chk("async_bf_en", 32'(bf_en), 0);
    chk("async_out_valid", 32'(bus.out_valid), 0);
    chk("async_out_last", 32'(bus.out_last), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_frame_done", 32'(frame_done), 0);
    chk("async_in_blk", 32'(bus.in_blk), 0);
    chk("async_out_blk", 32'(bus.out_blk), 0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    bus.in_valid = 1'b0;
    tick();

    // Randomized frames, one of them cut short by reset.
    for (int f = 0; f < 6; f++) begin
      int rk;
      rk = $urandom_range(5, 40);
      got_fd = 1'b0;
      n_hand = 0;
      start = 1'b1;
      bus.in_valid = ($urandom_range(0, 1) == 1);
      tick();
      for (int k = 0; k < 600 && !got_fd; k++) begin
        bus.in_valid  = ($urandom_range(0, 3) != 0);
        bus.out_ready = ($urandom_range(0, 3) != 0);
        start         = ($urandom_range(0, 19) == 0);
        if (f == 3 && k == rk) begin
          rst_n = 1'b0;
          tick();
          rst_n = 1'b1;
          break;
        end
        tick();
        if (s_fd) got_fd = 1'b1;
      end
      if (f != 3) begin
        chk("rand_frame_done_seen", 32'(got_fd), 1);
        chk("rand_handoffs", 32'(n_hand), FB);
      end
      start = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
